// File: rtl/rf_pkg.sv
// Shared definitions for the 8x32 register file write path.
// Provides register file widths, write-source encodings and the queued write-back entry type.
package rf_pkg;

  localparam int unsigned RF_ADDR_W = 3;
  localparam int unsigned RF_DATA_W = 32;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_ID  = 1'b1;

  typedef struct packed {
    logic                 src;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Write-back request channels (ALU and ID stage) plus the register file write port.
// master: pipeline/register-file side (drives requests, observes ready and w_*).
// slave : reg_writeback_ctrl side (accepts requests, drives ready and w_*).
interface reg_writeback_ctrl_if
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;

  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_addr;
  logic [DATA_W-1:0] id_data;

  logic [ADDR_W-1:0] w_addr;
  logic              w_enable;
  logic              w_select;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_id;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output id_valid, id_addr, id_data,
    input  alu_ready, id_ready,
    input  w_addr, w_enable, w_select, w_alu, w_id
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  id_valid, id_addr, id_data,
    output alu_ready, id_ready,
    output w_addr, w_enable, w_select, w_alu, w_id
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of write-back entries: up to two pushes (a older than b) and one pop per clock,
// plus a youngest-match lookup of two register addresses across all queued entries.
// Ports: clk, rst_n (sync, active-low); push_a/entry_a, push_b/entry_b; pop; head; count;
//        look_addr_0/1 -> hit_0/1, hit_data_0/1.
module wb_fifo
  import rf_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_a,
  input  wb_entry_t            entry_a,
  input  logic                 push_b,
  input  wb_entry_t            entry_b,
  input  logic                 pop,
  output wb_entry_t            head,
  output logic [CNT_W-1:0]     count,
  input  logic [RF_ADDR_W-1:0] look_addr_0,
  input  logic [RF_ADDR_W-1:0] look_addr_1,
  output logic                 hit_0,
  output logic                 hit_1,
  output logic [RF_DATA_W-1:0] hit_data_0,
  output logic [RF_DATA_W-1:0] hit_data_1
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] look_idx;

  // Pointer and occupancy state; validity of a slot is implied by its age relative to head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (pop) head_ptr <= head_ptr + PTR_W'(1);
      tail_ptr <= tail_ptr + PTR_W'(push_a) + PTR_W'(push_b);
      count    <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    end
  end

  // Entry storage; entry_b lands behind entry_a when both push together.
  always_ff @(posedge clk) begin
    if (push_a) mem[tail_ptr] <= entry_a;
    if (push_a && push_b) mem[tail_ptr + PTR_W'(1)] <= entry_b;
    else if (push_b)      mem[tail_ptr] <= entry_b;
  end

  assign head = mem[head_ptr];

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit_0      = 1'b0;
    hit_1      = 1'b0;
    hit_data_0 = '0;
    hit_data_1 = '0;
    look_idx   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      look_idx = head_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if (mem[look_idx].addr == look_addr_0) begin
          hit_0      = 1'b1;
          hit_data_0 = mem[look_idx].data;
        end
        if (mem[look_idx].addr == look_addr_1) begin
          hit_1      = 1'b1;
          hit_data_1 = mem[look_idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Write-side front end of the 8x32 register file. Accepts ALU and ID write-back requests,
// queues them in program order and commits the head entry to the register file every clock.
// Ports: clk, rst_n (sync, active-low); bus (slave: alu_*/id_* handshakes, w_* write port);
//        r_addr_0/1 -> pend_0/1, fwd_val_0/1 pending-write lookup; count (queued entries).
module reg_writeback_ctrl
  import rf_pkg::*;
#(
  parameter  int unsigned DATA_W     = RF_DATA_W,
  parameter  int unsigned ADDR_W     = RF_ADDR_W,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_writeback_ctrl_if.slave  bus,
  input  logic [ADDR_W-1:0]    r_addr_0,
  input  logic [ADDR_W-1:0]    r_addr_1,
  output logic                 pend_0,
  output logic                 pend_1,
  output logic [DATA_W-1:0]    fwd_val_0,
  output logic [DATA_W-1:0]    fwd_val_1,
  output logic [CNT_W-1:0]     count
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic                 push_alu;
  logic                 push_id;
  logic                 pop;
  wb_entry_t            entry_alu;
  wb_entry_t            entry_id;
  wb_entry_t            head;
  logic                 hit_0;
  logic                 hit_1;
  logic [RF_DATA_W-1:0] hit_data_0;
  logic [RF_DATA_W-1:0] hit_data_1;

  // Readiness looks only at registered occupancy; the ID slot is counted after a pending ALU request.
  assign bus.alu_ready = rst_n && (count < DEPTH_CNT);
  assign bus.id_ready  = rst_n && ((count + CNT_W'(bus.alu_valid)) < DEPTH_CNT);

  assign push_alu = bus.alu_valid && bus.alu_ready;
  assign push_id  = bus.id_valid  && bus.id_ready;
  assign pop      = rst_n && (count != '0);

  assign entry_alu = '{src: SRC_ALU, addr: RF_ADDR_W'(bus.alu_addr), data: RF_DATA_W'(bus.alu_data)};
  assign entry_id  = '{src: SRC_ID,  addr: RF_ADDR_W'(bus.id_addr),  data: RF_DATA_W'(bus.id_data)};

  // ALU goes in the older slot: its instruction precedes the one in ID.
  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_a      (push_alu),
    .entry_a     (entry_alu),
    .push_b      (push_id),
    .entry_b     (entry_id),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .look_addr_0 (RF_ADDR_W'(r_addr_0)),
    .look_addr_1 (RF_ADDR_W'(r_addr_1)),
    .hit_0       (hit_0),
    .hit_1       (hit_1),
    .hit_data_0  (hit_data_0),
    .hit_data_1  (hit_data_1)
  );

  // Head entry drives the write port; everything is zero when nothing commits.
  assign bus.w_enable = pop;
  assign bus.w_addr   = pop ? ADDR_W'(head.addr) : '0;
  assign bus.w_select = pop ? head.src : SRC_ALU;
  assign bus.w_alu    = pop ? DATA_W'(head.data) : '0;
  assign bus.w_id     = pop ? DATA_W'(head.data) : '0;

  assign pend_0    = rst_n && hit_0;
  assign pend_1    = rst_n && hit_1;
  assign fwd_val_0 = pend_0 ? DATA_W'(hit_data_0) : '0;
  assign fwd_val_1 = pend_1 ? DATA_W'(hit_data_1) : '0;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed and model-based checks of reg_writeback_ctrl with FIFO_DEPTH = 4.
module tb_reg_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  r_addr_0;
  logic [2:0]  r_addr_1;
  logic        pend_0;
  logic        pend_1;
  logic [31:0] fwd_val_0;
  logic [31:0] fwd_val_1;
  logic [2:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] rf     [8];
  logic [31:0] exp_rf [8];
  logic        rf_clr = 1'b0;
  int          wr_cnt = 0;

  logic [2:0]  q_addr [$];
  logic [31:0] q_data [$];
  logic        q_src  [$];

  always #5 clk = ~clk;

  reg_writeback_ctrl_if #(.ADDR_W(3), .DATA_W(32)) bus ();

  reg_writeback_ctrl #(.DATA_W(32), .ADDR_W(3), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .r_addr_0  (r_addr_0),
    .r_addr_1  (r_addr_1),
    .pend_0    (pend_0),
    .pend_1    (pend_1),
    .fwd_val_0 (fwd_val_0),
    .fwd_val_1 (fwd_val_1),
    .count     (count)
  );

  // Behaves as the register file: captures each commit from the write port.
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 32'h0;
    end else if (bus.w_enable) begin
      rf[bus.w_addr] <= bus.w_alu;
    end
    if (bus.w_enable) wr_cnt <= wr_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [2:0] aa, input logic [31:0] ad,
                       input logic iv, input logic [2:0] ia, input logic [31:0] id);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.id_valid  = iv; bus.id_addr  = ia; bus.id_data  = id;
  endtask

  // Leaves three entries queued (r2, r3, r4) with head r2.
  task automatic fill_three();
    drive(1'b1, 3'd1, 32'hA1, 1'b1, 3'd2, 32'hA2);
    tick();
    drive(1'b1, 3'd3, 32'hB3, 1'b1, 3'd4, 32'hB4);
    tick();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; r_addr_0 = 3'd0; r_addr_1 = 3'd0;
    drive(1'b1, 3'd0, 32'h0, 1'b1, 3'd0, 32'h0);
    repeat (2) tick();
    vectors++; if (bus.alu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_alu_ready: got %0b want 0", bus.alu_ready); end
    vectors++; if (bus.id_ready !== 1'b0) begin miscompares++; $display("FAIL reset_id_ready: got %0b want 0", bus.id_ready); end
    vectors++; if (bus.w_enable !== 1'b0) begin miscompares++; $display("FAIL reset_w_enable: got %0b want 0", bus.w_enable); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if (pend_0 !== 1'b0 || fwd_val_0 !== 32'h0) begin miscompares++; $display("FAIL reset_pend: got %0b/%0h want 0/0", pend_0, fwd_val_0); end
    drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_alu();
    drive(1'b1, 3'd3, 32'h0000_00AA, 1'b0, 3'd0, 32'h0);
    #1;
    vectors++; if (bus.alu_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %0b want 1", bus.alu_ready); end
    tick();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    #1;
    vectors++; if (bus.w_enable !== 1'b1 || bus.w_addr !== 3'd3 || bus.w_select !== 1'b0)
      begin miscompares++; $display("FAIL single_commit: got en=%0b addr=%0d sel=%0b want 1/3/0", bus.w_enable, bus.w_addr, bus.w_select); end
    vectors++; if (bus.w_alu !== 32'hAA || bus.w_id !== 32'hAA)
      begin miscompares++; $display("FAIL single_data: got alu=%0h id=%0h want aa/aa", bus.w_alu, bus.w_id); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL single_count1: got %0d want 1", count); end
    tick();
    vectors++; if (bus.w_enable !== 1'b0 || count !== 3'd0)
      begin miscompares++; $display("FAIL single_drained: got en=%0b count=%0d want 0/0", bus.w_enable, count); end
  endtask

  task automatic test_dual();
    drive(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22);
    #1;
    vectors++; if (bus.alu_ready !== 1'b1 || bus.id_ready !== 1'b1)
      begin miscompares++; $display("FAIL dual_ready: got %0b/%0b want 1/1", bus.alu_ready, bus.id_ready); end
    tick();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    #1;
    vectors++; if (count !== 3'd2 || bus.w_addr !== 3'd1 || bus.w_select !== 1'b0 || bus.w_alu !== 32'h11)
      begin miscompares++; $display("FAIL dual_first: got cnt=%0d addr=%0d sel=%0b data=%0h want 2/1/0/11", count, bus.w_addr, bus.w_select, bus.w_alu); end
    tick();
    vectors++; if (count !== 3'd1 || bus.w_addr !== 3'd2 || bus.w_select !== 1'b1 || bus.w_id !== 32'h22)
      begin miscompares++; $display("FAIL dual_second: got cnt=%0d addr=%0d sel=%0b data=%0h want 1/2/1/22", count, bus.w_addr, bus.w_select, bus.w_id); end
    tick();
    vectors++; if (bus.w_enable !== 1'b0) begin miscompares++; $display("FAIL dual_drained: got %0b want 0", bus.w_enable); end
  endtask

  task automatic test_backpressure();
    fill_three();
    vectors++; if (count !== 3'd3 || bus.w_addr !== 3'd2 || bus.w_select !== 1'b1)
      begin miscompares++; $display("FAIL bp_fill: got cnt=%0d addr=%0d sel=%0b want 3/2/1", count, bus.w_addr, bus.w_select); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd6, 32'hC0 + 32'(i), 1'b1, 3'd7, 32'hD7);
      #1;
      vectors++; if (bus.alu_ready !== 1'b1 || bus.id_ready !== 1'b0)
        begin miscompares++; $display("FAIL bp_ready[%0d]: got %0b/%0b want 1/0", i, bus.alu_ready, bus.id_ready); end
      vectors++; if (count !== 3'd3)
        begin miscompares++; $display("FAIL bp_count[%0d]: got %0d want 3", i, count); end
      tick();
    end
    drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    #1;
    for (int i = 0; i < 10 && count != 3'd0; i++) tick();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL bp_drain_timeout: got %0d want 0", count); end
  endtask

  task automatic test_forward();
    r_addr_0 = 3'd5; r_addr_1 = 3'd4;
    drive(1'b1, 3'd5, 32'h5, 1'b1, 3'd5, 32'h6);
    #1;
    vectors++; if (pend_0 !== 1'b0) begin miscompares++; $display("FAIL fwd_sameCycle: got %0b want 0", pend_0); end
    tick();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    #1;
    vectors++; if (pend_0 !== 1'b1 || fwd_val_0 !== 32'h6)
      begin miscompares++; $display("FAIL fwd_youngest: got %0b/%0h want 1/6", pend_0, fwd_val_0); end
    vectors++; if (pend_1 !== 1'b0 || fwd_val_1 !== 32'h0)
      begin miscompares++; $display("FAIL fwd_nomatch: got %0b/%0h want 0/0", pend_1, fwd_val_1); end
    vectors++; if (bus.w_alu !== 32'h5 || bus.w_select !== 1'b0)
      begin miscompares++; $display("FAIL fwd_headOrder: got %0h/%0b want 5/0", bus.w_alu, bus.w_select); end
    tick();
    r_addr_1 = 3'd5;
    #1;
    vectors++; if (pend_1 !== 1'b1 || fwd_val_1 !== 32'h6 || bus.w_select !== 1'b1)
      begin miscompares++; $display("FAIL fwd_headOnly: got %0b/%0h/%0b want 1/6/1", pend_1, fwd_val_1, bus.w_select); end
    tick();
    vectors++; if (pend_0 !== 1'b0 || fwd_val_0 !== 32'h0)
      begin miscompares++; $display("FAIL fwd_cleared: got %0b/%0h want 0/0", pend_0, fwd_val_0); end
  endtask

  task automatic test_reset_mid();
    int w0;
    fill_three();
    r_addr_0 = 3'd3;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.w_enable !== 1'b0 || bus.alu_ready !== 1'b0 || bus.id_ready !== 1'b0)
      begin miscompares++; $display("FAIL rstmid_gate: got en=%0b rdy=%0b/%0b want 0/0/0", bus.w_enable, bus.alu_ready, bus.id_ready); end
    vectors++; if (pend_0 !== 1'b0 || fwd_val_0 !== 32'h0 || bus.w_addr !== 3'd0 || bus.w_alu !== 32'h0)
      begin miscompares++; $display("FAIL rstmid_zero: got pend=%0b fwd=%0h addr=%0d data=%0h want 0", pend_0, fwd_val_0, bus.w_addr, bus.w_alu); end
    w0 = wr_cnt;
    tick();
    rst_n = 1'b1;
    #1;
    vectors++; if (count !== 3'd0 || bus.w_enable !== 1'b0)
      begin miscompares++; $display("FAIL rstmid_empty: got cnt=%0d en=%0b want 0/0", count, bus.w_enable); end
    repeat (3) tick();
    vectors++; if (wr_cnt !== w0) begin miscompares++; $display("FAIL rstmid_nowrites: got %0d writes want %0d", wr_cnt, w0); end
  endtask

  task automatic test_random();
    logic        av, iv, exp_ar, exp_ir, exp_pend;
    logic [2:0]  aa, ia;
    logic [31:0] ad, id, exp_fwd;
    rf_clr = 1'b1;
    tick();
    rf_clr = 1'b0;
    for (int i = 0; i < 8; i++) exp_rf[i] = 32'h0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      av = ($urandom_range(0, 9) < 7); iv = ($urandom_range(0, 9) < 6);
      aa = 3'($urandom_range(0, 7)); ia = 3'($urandom_range(0, 7));
      ad = $urandom; id = $urandom;
      drive(av, aa, ad, iv, ia, id);
      r_addr_0 = 3'($urandom_range(0, 7));
      #1;
      exp_ar = (q_addr.size() < 4);
      exp_ir = (q_addr.size() + int'(av) < 4);
      vectors++; if (bus.alu_ready !== exp_ar || bus.id_ready !== exp_ir)
        begin miscompares++; $display("FAIL rnd_ready[%0d]: got %0b/%0b want %0b/%0b", cyc, bus.alu_ready, bus.id_ready, exp_ar, exp_ir); end
      if (q_addr.size() > 0) begin
        vectors++; if (bus.w_enable !== 1'b1 || bus.w_addr !== q_addr[0] || bus.w_alu !== q_data[0] || bus.w_select !== q_src[0])
          begin miscompares++; $display("FAIL rnd_head[%0d]: got %0b/%0d/%0h/%0b want 1/%0d/%0h/%0b", cyc, bus.w_enable, bus.w_addr, bus.w_alu, bus.w_select, q_addr[0], q_data[0], q_src[0]); end
      end else begin
        vectors++; if (bus.w_enable !== 1'b0) begin miscompares++; $display("FAIL rnd_idle[%0d]: got %0b want 0", cyc, bus.w_enable); end
      end
      exp_pend = 1'b0; exp_fwd = 32'h0;
      foreach (q_addr[k]) if (q_addr[k] == r_addr_0) begin exp_pend = 1'b1; exp_fwd = q_data[k]; end
      vectors++; if (pend_0 !== exp_pend || fwd_val_0 !== exp_fwd)
        begin miscompares++; $display("FAIL rnd_fwd[%0d]: got %0b/%0h want %0b/%0h", cyc, pend_0, fwd_val_0, exp_pend, exp_fwd); end
      @(posedge clk);
      if (q_addr.size() > 0) begin
        exp_rf[q_addr[0]] = q_data[0];
        void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_src.pop_front());
      end
      if (av && exp_ar) begin q_addr.push_back(aa); q_data.push_back(ad); q_src.push_back(1'b0); end
      if (iv && exp_ir) begin q_addr.push_back(ia); q_data.push_back(id); q_src.push_back(1'b1); end
      #1;
    end
    drive(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    repeat (6) begin
      @(posedge clk);
      if (q_addr.size() > 0) begin
        exp_rf[q_addr[0]] = q_data[0];
        void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_src.pop_front());
      end
      #1;
    end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rnd_drain: got %0d want 0", count); end
    for (int r = 0; r < 8; r++) begin
      vectors++; if (rf[r] !== exp_rf[r])
        begin miscompares++; $display("FAIL rnd_rf[%0d]: got %0h want %0h", r, rf[r], exp_rf[r]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_dual();
    test_backpressure();
    test_forward();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
